// File: rtl/dmem_store_rmw.sv
// Store path into a byte-enable-less single-port BRAM: word stores write directly,
// byte/halfword stores read the word, then write it back with the lane(s) merged.
module dmem_store_rmw #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StoreReq,
  input  logic [1:0]    ByteAccess,
  input  logic [31:0]   Addr,
  input  logic [31:0]   WriteData,
  output logic          Stall,
  output logic          Misaligned,
  output logic [AW-1:0] MemAdr,
  output logic          MemWE,
  output logic [31:0]   MemWData,
  input  logic [31:0]   MemRData
);

  typedef enum logic [0:0] {IDLE = 1'b0, WR = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] la_q, la_d;
  logic [1:0]    lo_q, lo_d;
  logic [1:0]    ls_q, ls_d;
  logic [15:0]   ld_q, ld_d;

  logic          stall_s, mis_s, we_s;
  logic [AW-1:0] adr_s;
  logic [31:0]   wdata_s;
  logic          is_sb_s, is_sh_s, is_sw_s, mis_cond_s;
  logic          unused_addr_s;

  // Replace the addressed byte or halfword lane of the read word with the latched data.
  function automatic logic [31:0] merge_lane(input logic [31:0] rdata,
                                             input logic [1:0]  lo,
                                             input logic [1:0]  ls,
                                             input logic [15:0] ld);
    logic [31:0] res;
    res = rdata;
    case (ls)
      2'b01: begin
        case (lo)
          2'b00:   res = {rdata[31:8], ld[7:0]};
          2'b01:   res = {rdata[31:16], ld[7:0], rdata[7:0]};
          2'b10:   res = {rdata[31:24], ld[7:0], rdata[15:0]};
          2'b11:   res = {ld[7:0], rdata[23:0]};
          default: res = rdata;
        endcase
      end
      2'b10: begin
        if (lo[1]) begin
          res = {ld, rdata[15:0]};
        end else begin
          res = {rdata[31:16], ld};
        end
      end
      default: res = rdata;
    endcase
    return res;
  endfunction

  assign is_sb_s    = (ByteAccess == 2'b01);
  assign is_sh_s    = (ByteAccess == 2'b10);
  assign is_sw_s    = ~is_sb_s & ~is_sh_s;
  assign mis_cond_s = (is_sw_s & (Addr[1:0] != 2'b00)) | (is_sh_s & Addr[0]);

  assign unused_addr_s = ^Addr[31:AW+2];

  // State and latched store context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      la_q    <= '0;
      lo_q    <= 2'b00;
      ls_q    <= 2'b00;
      ld_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      la_q    <= la_d;
      lo_q    <= lo_d;
      ls_q    <= ls_d;
      ld_q    <= ld_d;
    end
  end

  // Next state and memory-side controls.
  always_comb begin
    state_d = state_q;
    la_d    = la_q;
    lo_d    = lo_q;
    ls_d    = ls_q;
    ld_d    = ld_q;
    stall_s = 1'b0;
    mis_s   = 1'b0;
    we_s    = 1'b0;
    adr_s   = Addr[AW+1:2];
    wdata_s = WriteData;
    case (state_q)
      IDLE: begin
        if (StoreReq) begin
          if (mis_cond_s) begin
            mis_s = 1'b1;
          end else if (is_sb_s || is_sh_s) begin
            stall_s = 1'b1;
            la_d    = Addr[AW+1:2];
            lo_d    = Addr[1:0];
            ls_d    = ByteAccess;
            ld_d    = WriteData[15:0];
            state_d = WR;
          end else begin
            we_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        adr_s   = la_q;
        we_s    = 1'b1;
        wdata_s = merge_lane(MemRData, lo_q, ls_q, ld_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the handshake and write strobe so an in-flight write is dropped at once.
  assign Stall      = stall_s & ~reset;
  assign Misaligned = mis_s & ~reset;
  assign MemWE      = we_s & ~reset;
  assign MemAdr     = adr_s;
  assign MemWData   = wdata_s;

endmodule

// File: doc/dmem_store_rmw.md
# dmem_store_rmw

Store-side companion to the data-memory load aligner. Sits in the MEM stage between the pipeline and a single-port BRAM that has no byte enables and a one-cycle synchronous read. Word stores go straight through in one cycle. Byte and halfword stores (sb/sh) run as a two-cycle read-modify-write, stalling the pipeline for one cycle.

## Interface
Parameters:
- AW, 10, BRAM word-address width; the memory word index is Addr[AW+1:2].

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE.
- StoreReq  input  1  store request valid in MEM stage.
- ByteAccess  input  2  store size:
  - 00 = sw
  - 01 = sb
  - 10 = sh
  - 11 = treated as sw
- Addr  input  32  byte address of the store.
- WriteData  input  32  store data; sb uses [7:0], sh uses [15:0].
- Stall  output  1  holds the pipeline (MEM and earlier) for the current cycle.
- Misaligned  output  1  one-cycle flag; the store was dropped.
- MemAdr  output  AW  BRAM word address.
- MemWE  output  1  BRAM write enable.
- MemWData  output  32  BRAM write data.
- MemRData  input  32  BRAM read data; valid the cycle after MemAdr is sampled.

## Operation
- States: IDLE and WR.
- Registers:
  - state
  - latched word address LA (AW bits)
  - offset LO (2 bits)
  - size LS (2 bits)
  - data LD (16 bits)
- Misaligned conditions:
  - sw with Addr[1:0]≠00
  - sh with Addr[0]=1
  - sb is never misaligned.
- IDLE, StoreReq=0: MemWE=0, Stall=0, MemAdr=Addr[AW+1:2]. The read port stays usable by loads.
- IDLE, StoreReq=1, misaligned: Misaligned=1, MemWE=0, Stall=0; stay in IDLE.
- IDLE, StoreReq=1, sw aligned: MemWE=1, MemWData=WriteData, MemAdr=Addr[AW+1:2], Stall=0; stay in IDLE.
- IDLE, StoreReq=1, sb or sh aligned:
  - MemWE=0, MemAdr=Addr[AW+1:2] (this is the read), Stall=1.
  - Latch LA/LO/LS and LD=WriteData[15:0]; go to WR.
- WR:
  - MemAdr=LA, MemWE=1, Stall=0; go to IDLE unconditionally.
  - MemWData = MemRData with only the addressed lane(s) replaced:
    - sb, LO=n: byte n (bits 8n+7:8n) = LD[7:0].
    - sh, LO[1]=0: bits 15:0 = LD.
    - sh, LO[1]=1: bits 31:16 = LD.
  - StoreReq/Addr/WriteData are ignored in WR. The pipeline is still presenting the same store and advances at the end of this cycle.
- Misaligned, Stall, MemWE, MemWData and MemAdr are combinational from state, registers and inputs. No output depends on MemRData except MemWData in WR.

## Timing
- Reset values: state=IDLE, LA=0, LO=0, LS=0, LD=0.
- While reset is high: MemWE=0, Stall=0, Misaligned=0, regardless of inputs.
- Latency:
  - sw: write occurs at the edge ending the request cycle (1 cycle, no stall).
  - sb/sh: read at edge 0, merged write at edge 1; Stall is high for exactly one cycle.
- Handshake: while Stall=1 the requester holds StoreReq, ByteAccess, Addr and WriteData stable. A new request is evaluated in the cycle after WR.
- Back-to-back sb/sh: cycle pattern is IDLE(stall), WR, IDLE(stall), WR. There is no bubble beyond the single stall per store.
- Reset asserted in WR: the write is abandoned; MemWE drops immediately (asynchronously) and state returns to IDLE. Memory is unchanged.
- Reset released: first request is evaluated on the first rising edge with reset low.

## Test plan
- Word store:
  - Stimulus: sw Addr=0x10, WriteData=0xDEADBEEF.
  - Response: same cycle MemWE=1, MemAdr=4, MemWData=0xDEADBEEF, Stall=0; word 4 reads 0xDEADBEEF afterwards.
- Byte store:
  - Stimulus: word 4 holds 0xAABBCCDD; sb Addr=0x11, WriteData=0x000000EE.
  - Response: cycle0 Stall=1, MemWE=0; cycle1 MemWE=1, MemWData=0xAABBEEDD; word 4 then reads 0xAABBEEDD.
- Halfword store:
  - Stimulus: word 4 holds 0xAABBCCDD; sh Addr=0x12, WriteData=0xFFFF1234.
  - Response: cycle1 MemWData=0x1234CCDD; lower half untouched.
- Misaligned stores:
  - Stimulus: sh Addr=0x13, then sw Addr=0x12.
  - Response: each cycle Misaligned=1, MemWE=0, Stall=0; memory unchanged.
- Back-to-back byte stores:
  - Stimulus: word 4 holds 0x00000000; sb Addr=0x10 data 0x11, then sb Addr=0x13 data 0x44.
  - Response: first write 0x00000011, second write 0x44000011; Stall pattern 1,0,1,0.
- Reset mid-operation:
  - Stimulus: sb Addr=0x10; assert reset during WR.
  - Response: MemWE falls immediately, state=IDLE, word 4 unchanged; the next sw after release completes normally.
